// File: rtl/vga_timing_gen_if.sv
// Pixel request bus between the raster timing generator (master) and the frame source (slave).
// The source answers each request with pix_* exactly one cycle later.
interface vga_timing_gen_if;
  logic       req_valid;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic       frame_start;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

  modport master (
    output req_valid, req_x, req_y, frame_start,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  req_valid, req_x, req_y, frame_start,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster origin: counts h/v, requests pixels by coordinate, emits registered RGB/HS/VS/BLANK_N.
// Optional colour bars are compiled in when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic                     VGA_CLK,
  input  logic                     reset_n,
  vga_timing_gen_if.master         req_if,
  input  logic                     pattern_en,
  output logic [7:0]               oVGA_R,
  output logic [7:0]               oVGA_G,
  output logic [7:0]               oVGA_B,
  output logic                     oVGA_HS,
  output logic                     oVGA_VS,
  output logic                     oVGA_SYNC_N,
  output logic                     oVGA_BLANK_N
);

  localparam int unsigned HTotal = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HLast   = 10'(HTotal - 1);
  localparam logic [9:0] VLast   = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncLo = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HSyncHi = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VSyncLo = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VSyncHi = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Stage 0: counters and request/raw-timing registers
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       req_valid_q, req_valid_d;
  logic [9:0] req_x_q, req_x_d, req_y_q, req_y_d;
  logic       frame_start_q, frame_start_d;
  logic       hs0_q, hs0_d, vs0_q, vs0_d;
  // Stage 1: timing delayed to line up with the source's pixel
  logic       hs1_q, vs1_q, blank1_q;
  // Stage 2: output registers
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs2_q, vs2_q, blank2_q;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end
    req_valid_d   = (h_d < HVis) && (v_d < VVis);
    req_x_d       = req_valid_d ? h_d : '0;
    req_y_d       = req_valid_d ? v_d : '0;
    frame_start_d = (h_d == '0) && (v_d == '0);
    hs0_d         = !((h_d >= HSyncLo) && (h_d < HSyncHi));
    vs0_d         = !((v_d >= VSyncLo) && (v_d < VSyncHi));
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BarW = 10'(H_VISIBLE / 8);

  logic       pat_q, pat_d;
  logic       pat1_q;
  logic [2:0] bar1_q, bar1_d;

  always_comb begin
    // Latched on the edge that enters (0,0) so a whole frame sees one mode
    pat_d  = frame_start_d ? pattern_en : pat_q;
    bar1_d = 3'(req_x_q / BarW);
  end

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (blank1_q) begin
      if (pat1_q) begin
        // Bar index bits map straight onto missing primaries: W,Y,C,G,M,R,B,K
        r_d = {8{!bar1_q[1]}};
        g_d = {8{!bar1_q[2]}};
        b_d = {8{!bar1_q[0]}};
      end else begin
        r_d = req_if.pix_r;
        g_d = req_if.pix_g;
        b_d = req_if.pix_b;
      end
    end
  end

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      pat_q  <= 1'b0;
      pat1_q <= 1'b0;
      bar1_q <= '0;
    end else begin
      pat_q  <= pat_d;
      pat1_q <= pat_q;
      bar1_q <= bar1_d;
    end
  end
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (blank1_q) begin
      r_d = req_if.pix_r;
      g_d = req_if.pix_g;
      b_d = req_if.pix_b;
    end
  end
`endif

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      h_q           <= HLast;
      v_q           <= VLast;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      frame_start_q <= 1'b0;
      hs0_q         <= 1'b1;
      vs0_q         <= 1'b1;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      blank1_q      <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      blank2_q      <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      req_valid_q   <= req_valid_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      frame_start_q <= frame_start_d;
      hs0_q         <= hs0_d;
      vs0_q         <= vs0_d;
      hs1_q         <= hs0_q;
      vs1_q         <= vs0_q;
      blank1_q      <= req_valid_q;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      blank2_q      <= blank1_q;
    end
  end

  assign req_if.req_valid   = req_valid_q;
  assign req_if.req_x       = req_x_q;
  assign req_if.req_y       = req_y_q;
  assign req_if.frame_start = frame_start_q;

  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs2_q;
  assign oVGA_VS      = vs2_q;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_BLANK_N = blank2_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster: a source model answers requests and queues the
// expected colour; a negedge monitor checks requests, syncs and colours against position arithmetic.
module tb_vga_timing_gen;
  localparam int HV = 16, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pattern_en;
  logic [7:0] o_r, o_g, o_b;
  logic       o_hs, o_vs, o_sync_n, o_blank_n;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .VGA_CLK      (clk),
    .reset_n      (reset_n),
    .req_if       (bus),
    .pattern_en   (pattern_en),
    .oVGA_R       (o_r),
    .oVGA_G       (o_g),
    .oVGA_B       (o_b),
    .oVGA_HS      (o_hs),
    .oVGA_VS      (o_vs),
    .oVGA_SYNC_N  (o_sync_n),
    .oVGA_BLANK_N (o_blank_n)
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Colour bars, left to right
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic [23:0] exp_q [$];
  int          cyc = 0;
  logic        pat_model = 1'b0;
  logic [7:0]  rnd_b = 8'h00;
  logic [7:0]  rnd_junk = 8'h00;

  initial forever begin
    @(negedge clk);
    rnd_b    = 8'($urandom);
    rnd_junk = 8'($urandom);
  end

  // Cycle index since reset release; cyc-1 is the raster position presented on the request bus
  always @(posedge clk) begin
    if (!reset_n) begin
      cyc       <= 0;
      pat_model <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (cyc % FT == 0) pat_model <= pattern_en;
    end
  end

  // Frame source: answers every visible request one cycle later, junk otherwise
  always @(posedge clk) begin
    if (reset_n && bus.req_valid) begin
      bus.pix_r <= bus.req_x[7:0];
      bus.pix_g <= bus.req_y[7:0];
      bus.pix_b <= rnd_b;
`ifdef VGA_TEST_PATTERN_EN
      if (pat_model) exp_q.push_back(bars[int'(bus.req_x) / (HV / 8)]);
      else           exp_q.push_back({bus.req_x[7:0], bus.req_y[7:0], rnd_b});
`else
      exp_q.push_back({bus.req_x[7:0], bus.req_y[7:0], rnd_b});
`endif
    end else begin
      bus.pix_r <= rnd_junk;
      bus.pix_g <= ~rnd_junk;
      bus.pix_b <= rnd_junk ^ 8'h5A;
    end
  end

  task automatic chk_req_reset(input string tag);
    chk({tag, "_req_valid"}, bus.req_valid, 0);
    chk({tag, "_req_xy"}, {bus.req_x, bus.req_y}, 0);
    chk({tag, "_frame_start"}, bus.frame_start, 0);
  endtask

  task automatic chk_out_reset(input string tag);
    chk({tag, "_rgb"}, {o_r, o_g, o_b}, 0);
    chk({tag, "_hs"}, o_hs, 1);
    chk({tag, "_vs"}, o_vs, 1);
    chk({tag, "_blank_n"}, o_blank_n, 0);
  endtask

  // Monitor
  initial begin
    int last_fs;
    int p, h, v;
    logic vis;
    logic [23:0] e;
    last_fs = -1;
    forever begin
      @(negedge clk);
      chk("sync_n", o_sync_n, 0);
      if (!reset_n) begin
        last_fs = -1;
        chk_req_reset("in_reset");
        chk_out_reset("in_reset");
      end else begin
        if (cyc >= 1) begin
          p   = cyc - 1;
          h   = p % HT;
          v   = (p / HT) % VT;
          vis = (h < HV) && (v < VV);
          chk("req_valid", bus.req_valid, vis);
          chk("req_x", bus.req_x, vis ? h : 0);
          chk("req_y", bus.req_y, vis ? v : 0);
          chk("frame_start", bus.frame_start, (h == 0) && (v == 0));
          if (bus.frame_start) begin
            if (last_fs >= 0) chk("frame_spacing", cyc - last_fs, FT);
            last_fs = cyc;
          end
        end else begin
          chk_req_reset("post_release");
        end
        if (cyc >= 3) begin
          p   = cyc - 3;
          h   = p % HT;
          v   = (p / HT) % VT;
          vis = (h < HV) && (v < VV);
          chk("blank_n", o_blank_n, vis);
          chk("hs", o_hs, !((h >= HV + HF) && (h < HV + HF + HS)));
          chk("vs", o_vs, !((v >= VV + VF) && (v < VV + VF + VS)));
          if (vis) begin
            if (exp_q.size() == 0) begin
              chk("scoreboard_nonempty", 0, 1);
            end else begin
              e = exp_q.pop_front();
              chk("rgb", {o_r, o_g, o_b}, e);
            end
          end else begin
            chk("rgb_blanked", {o_r, o_g, o_b}, 0);
          end
        end else begin
          chk_out_reset("pipe_fill");
        end
      end
    end
  end

  initial begin
    bit found;
    reset_n    = 1'b0;
    pattern_en = 1'b0;
    repeat (3) @(posedge clk);
    #5 reset_n = 1'b1;
    repeat (100) @(posedge clk);

    // Change pattern_en mid-frame only; each frame uses the value present at its (0,0)
    for (int f = 0; f < 4; f++) begin
      pattern_en = (f == 0) ? 1'b1 : (f == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      repeat (FT) @(posedge clk);
    end

    // Asynchronous reset at (h=10, v=3)
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      @(negedge clk);
      if (reset_n && cyc >= 1 && ((cyc - 1) % FT) == 3 * HT + 10) found = 1'b1;
    end
    chk("reset_point_found", found, 1);
    #5 reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk_req_reset("async_reset");
    chk_out_reset("async_reset");
    repeat (3) @(posedge clk);
    #5 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_req", {bus.req_valid, bus.frame_start}, 2'b11);
    chk("restart_xy", {bus.req_x, bus.req_y}, 0);

    pattern_en = 1'b1;
    repeat (FT / 2) @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      pattern_en = 1'($urandom_range(0, 1));
      repeat (FT) @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
